// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the data-memory pipeline stage.
//   state_t         - access FSM states (IDLE, ACCESS)
//   CNT_W           - width of the access timeout counter
//   TIMEOUT_DEFAULT - default number of ACCESS cycles before an abort
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W           = 8;
    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_stage.sv
// mem_stage: data-memory stage of the 16-bit pipelined CPU.
// Takes the EX/MEM register contents, runs a req/ack access to the data RAM
// for loads and stores (stalling upstream while it waits), and presents a
// registered write-back slot to MEM/WB.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   DataAddress, DataIn         - address / ALU result, store data
//   ReadMem, WriteMem           - load / store request
//   quarter, write              - destination register, register-write flag
//   stall                       - combinational hold for upstream stages
//   ram_req, ram_we             - registered RAM request and direction
//   ram_addr, ram_wdata         - registered RAM address and store data
//   ram_ack, ram_rdata          - RAM completion pulse and load data
//   wb_valid, wb_write          - write-back slot valid, register-file write
//   wb_quarter, wb_data         - write-back destination and value
//   mem_err                     - one-cycle pulse on timeout abort
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] DataAddress,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ReadMem,
    input  logic              WriteMem,
    input  logic [1:0]        quarter,
    input  logic              write,
    output logic              stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              wb_valid,
    output logic              wb_write,
    output logic [1:0]        wb_quarter,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    // Counter value seen during the last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                req_r, req_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                is_load_r, is_load_s;
    logic [1:0]          quarter_r, quarter_s;
    logic                write_r, write_s;
    logic                wb_valid_r, wb_valid_s;
    logic                wb_write_r, wb_write_s;
    logic [1:0]          wb_quarter_r, wb_quarter_s;
    logic [DATA_W-1:0]   wb_data_r, wb_data_s;
    logic                mem_err_r, mem_err_s;
    logic                stall_s;
    logic                timeout_s;

    // Next-state, capture, counter and write-back slot computation.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        req_s        = req_r;
        we_s         = we_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        is_load_s    = is_load_r;
        quarter_s    = quarter_r;
        write_s      = write_r;
        wb_valid_s   = 1'b0;
        wb_write_s   = 1'b0;
        wb_quarter_s = wb_quarter_r;
        wb_data_s    = wb_data_r;
        mem_err_s    = 1'b0;
        stall_s      = 1'b0;
        timeout_s    = (cnt_r == CNT_LAST);

        case (state_r)
            IDLE: begin
                if (ReadMem || WriteMem) begin
                    // Launch the access; the slot behind it is a bubble.
                    stall_s   = 1'b1;
                    state_s   = ACCESS;
                    cnt_s     = {CNT_W{1'b0}};
                    req_s     = 1'b1;
                    we_s      = WriteMem & ~ReadMem;
                    addr_s    = DataAddress;
                    wdata_s   = DataIn;
                    is_load_s = ReadMem;
                    quarter_s = quarter;
                    write_s   = write;
                end else begin
                    // Non-memory op retires with the ALU result.
                    wb_valid_s   = 1'b1;
                    wb_write_s   = write;
                    wb_quarter_s = quarter;
                    wb_data_s    = DataAddress;
                end
            end
            ACCESS: begin
                if (ram_ack) begin
                    // Ack wins over a coincident timeout.
                    state_s      = IDLE;
                    req_s        = 1'b0;
                    wb_valid_s   = 1'b1;
                    wb_quarter_s = quarter_r;
                    if (is_load_r) begin
                        wb_write_s = write_r;
                        wb_data_s  = ram_rdata;
                    end else begin
                        wb_write_s = 1'b0;
                        wb_data_s  = {DATA_W{1'b0}};
                    end
                end else if (timeout_s) begin
                    // Abort: retire as a non-writing slot and flag the error.
                    state_s      = IDLE;
                    req_s        = 1'b0;
                    wb_valid_s   = 1'b1;
                    wb_quarter_s = quarter_r;
                    wb_data_s    = {DATA_W{1'b0}};
                    mem_err_s    = 1'b1;
                end else begin
                    stall_s = 1'b1;
                    if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // State, capture and write-back registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            is_load_r    <= 1'b0;
            quarter_r    <= 2'b00;
            write_r      <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_write_r   <= 1'b0;
            wb_quarter_r <= 2'b00;
            wb_data_r    <= {DATA_W{1'b0}};
            mem_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            req_r        <= req_s;
            we_r         <= we_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            is_load_r    <= is_load_s;
            quarter_r    <= quarter_s;
            write_r      <= write_s;
            wb_valid_r   <= wb_valid_s;
            wb_write_r   <= wb_write_s;
            wb_quarter_r <= wb_quarter_s;
            wb_data_r    <= wb_data_s;
            mem_err_r    <= mem_err_s;
        end
    end

    // Stall is forced low while reset is asserted.
    assign stall      = rst_n & stall_s;
    assign ram_req    = req_r;
    assign ram_we     = we_r;
    assign ram_addr   = addr_r;
    assign ram_wdata  = wdata_r;
    assign wb_valid   = wb_valid_r;
    assign wb_write   = wb_write_r;
    assign wb_quarter = wb_quarter_r;
    assign wb_data    = wb_data_r;
    assign mem_err    = mem_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (TIMEOUT=4).
// Directed table of ALU ops, hand sequences for reset, load, store,
// timeout and reset-mid-access, then randomized traffic against a
// transaction-level reference model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] DataAddress;
    logic [15:0] DataIn;
    logic        ReadMem;
    logic        WriteMem;
    logic [1:0]  quarter;
    logic        write;
    logic        stall;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_ack;
    logic [15:0] ram_rdata;
    logic        wb_valid;
    logic        wb_write;
    logic [1:0]  wb_quarter;
    logic [15:0] wb_data;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .DataAddress(DataAddress), .DataIn(DataIn),
        .ReadMem(ReadMem), .WriteMem(WriteMem),
        .quarter(quarter), .write(write),
        .stall(stall),
        .ram_req(ram_req), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .wb_valid(wb_valid), .wb_write(wb_write),
        .wb_quarter(wb_quarter), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One full cycle: inputs set after a negedge are sampled at the posedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one memory op from IDLE until ram_req drops. ack_after is the
    // number of ACCESS cycles before the ack cycle (-1: never ack).
    task automatic mem_access(input bit rd, input bit wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [1:0] q, input bit w,
                              input int ack_after, input logic [15:0] rdata,
                              output int stall_cnt, output int req_cnt);
        bit done;
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        ReadMem = rd; WriteMem = wr; DataAddress = addr; DataIn = wd;
        quarter = q; write = w; ram_ack = 1'b0;
        #1;
        if (stall) stall_cnt++;
        tick();
        // Inputs change during ACCESS and must be ignored.
        ReadMem = 1'b0; WriteMem = 1'b0; DataAddress = ~addr; DataIn = ~wd;
        quarter = ~q; write = ~w;
        for (int i = 0; i < 64; i++) begin
            if (!ram_req) begin
                done = 1'b1;
                break;
            end
            req_cnt++;
            chk("acc_ram_we", {31'd0, ram_we}, {31'd0, (wr & ~rd)});
            chk("acc_ram_addr", {16'd0, ram_addr}, {16'd0, addr});
            if (wr && !rd) chk("acc_ram_wdata", {16'd0, ram_wdata}, {16'd0, wd});
            chk("acc_wb_valid", {31'd0, wb_valid}, 32'd0);
            if (i == ack_after) begin
                ram_ack = 1'b1;
                ram_rdata = rdata;
            end else begin
                ram_ack = 1'b0;
                ram_rdata = 16'hDEAD;
            end
            #1;
            if (stall) stall_cnt++;
            tick();
            ram_ack = 1'b0;
        end
        if (!done) chk("acc_bound", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  q;
        logic        w;
        logic        exp_write;
        logic [1:0]  exp_q;
        logic [15:0] exp_data;
    } alu_vec_t;

    alu_vec_t alu_tab [4];

    // Reference model state for the randomized phase.
    bit          m_busy;
    int          m_age;
    bit          m_rd;
    logic [1:0]  m_q;
    logic        m_w;
    logic        e_stall, e_req, e_we, e_wbv, e_wbw, e_err;
    logic [15:0] e_addr, e_wdata, e_wbd;
    logic [1:0]  e_wbq;

    initial begin
        int sc, rc;

        alu_tab[0] = '{16'h1234, 2'd2, 1'b1, 1'b1, 2'd2, 16'h1234};
        alu_tab[1] = '{16'hFFFF, 2'd3, 1'b0, 1'b0, 2'd3, 16'hFFFF};
        alu_tab[2] = '{16'h0000, 2'd0, 1'b1, 1'b1, 2'd0, 16'h0000};
        alu_tab[3] = '{16'h8001, 2'd1, 1'b1, 1'b1, 2'd1, 16'h8001};

        // Reset held for two cycles with a pending load request.
        rst_n = 1'b0; ReadMem = 1'b1; WriteMem = 1'b0; DataAddress = 16'h0040;
        DataIn = 16'h5555; quarter = 2'd1; write = 1'b1; ram_ack = 1'b0; ram_rdata = 16'h0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_stall", {31'd0, stall}, 32'd0);
            tick();
            chk("rst_outs", {8'd0, ram_req, ram_we, wb_valid, wb_write, wb_quarter, mem_err, 1'b0,
                             ram_addr}, 32'd0);
            chk("rst_data", {ram_wdata, wb_data}, 32'd0);
        end
        rst_n = 1'b1; ReadMem = 1'b0;

        // Table of ALU ops, one per cycle.
        for (int i = 0; i < 4; i++) begin
            DataAddress = alu_tab[i].addr; quarter = alu_tab[i].q; write = alu_tab[i].w;
            #1;
            chk("alu_stall", {31'd0, stall}, 32'd0);
            tick();
            chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("alu_wb_write", {31'd0, wb_write}, {31'd0, alu_tab[i].exp_write});
            chk("alu_wb_quarter", {30'd0, wb_quarter}, {30'd0, alu_tab[i].exp_q});
            chk("alu_wb_data", {16'd0, wb_data}, {16'd0, alu_tab[i].exp_data});
            chk("alu_ram_req", {31'd0, ram_req}, 32'd0);
        end

        // Load with ack on the fourth request cycle.
        mem_access(1'b1, 1'b0, 16'h0040, 16'h0000, 2'd3, 1'b1, 3, 16'hBEEF, sc, rc);
        chk("ld_stall_cycles", sc, 32'd4);
        chk("ld_req_cycles", rc, 32'd4);
        chk("ld_wb", {13'd0, wb_valid, wb_write, wb_quarter, mem_err, wb_data}, {13'd0, 1'b1, 1'b1, 2'd3, 1'b0, 16'hBEEF});

        // Store with ack on the second request cycle.
        mem_access(1'b0, 1'b1, 16'h0010, 16'hA5A5, 2'd1, 1'b1, 1, 16'h0000, sc, rc);
        chk("st_stall_cycles", sc, 32'd2);
        chk("st_wb", {13'd0, wb_valid, wb_write, wb_quarter, mem_err, wb_data}, {13'd0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0000});

        // Read and write both set: read wins.
        mem_access(1'b1, 1'b1, 16'h0022, 16'h1111, 2'd2, 1'b1, 0, 16'h7777, sc, rc);
        chk("rw_stall_cycles", sc, 32'd1);
        chk("rw_wb", {13'd0, wb_valid, wb_write, wb_quarter, mem_err, wb_data}, {13'd0, 1'b1, 1'b1, 2'd2, 1'b0, 16'h7777});

        // Load with no ack: timeout after TO request cycles.
        mem_access(1'b1, 1'b0, 16'h0080, 16'h0000, 2'd2, 1'b1, -1, 16'h0000, sc, rc);
        chk("to_req_cycles", rc, TO);
        chk("to_stall_cycles", sc, TO);
        chk("to_err", {29'd0, wb_valid, wb_write, mem_err}, {29'd0, 1'b1, 1'b0, 1'b1});
        DataAddress = 16'h00AA; quarter = 2'd0; write = 1'b1;
        #1;
        chk("to_idle_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("to_err_pulse", {31'd0, mem_err}, 32'd0);
        chk("to_idle_retire", {14'd0, wb_valid, wb_write, wb_data}, {14'd0, 1'b1, 1'b1, 16'h00AA});

        // Load then store, reset during the store access.
        mem_access(1'b1, 1'b0, 16'h0100, 16'h0000, 2'd1, 1'b1, 0, 16'hC0DE, sc, rc);
        chk("b2b_ld_wb", {13'd0, wb_valid, wb_write, wb_quarter, mem_err, wb_data}, {13'd0, 1'b1, 1'b1, 2'd1, 1'b0, 16'hC0DE});
        chk("b2b_gap", {31'd0, ram_req}, 32'd0);
        WriteMem = 1'b1; DataAddress = 16'h0200; DataIn = 16'h3333;
        #1;
        chk("b2b_st_stall", {31'd0, stall}, 32'd1);
        tick();
        WriteMem = 1'b0;
        chk("b2b_st_req", {31'd0, ram_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("b2b_rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("b2b_rst_outs", {29'd0, ram_req, mem_err, wb_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("b2b_after_rst", {30'd0, ram_req, mem_err}, 32'd0);

        // Randomized traffic against the reference model.
        m_busy = 1'b0; m_age = 0; m_rd = 1'b0; m_q = 2'd0; m_w = 1'b0;
        e_req = 1'b0; e_we = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
        e_wbv = 1'b0; e_wbw = 1'b0; e_wbq = 2'd0; e_wbd = 16'h0; e_err = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst_n       = (n == 0 || $urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            ReadMem     = ($urandom_range(0, 99) < 30);
            WriteMem    = ($urandom_range(0, 99) < 30);
            DataAddress = 16'($urandom);
            DataIn      = 16'($urandom);
            quarter     = 2'($urandom);
            write       = 1'($urandom);
            ram_ack     = ($urandom_range(0, 99) < 25);
            ram_rdata   = 16'($urandom);

            if (!rst_n) begin
                e_stall = 1'b0; m_busy = 1'b0;
                e_req = 1'b0; e_we = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
                e_wbv = 1'b0; e_wbw = 1'b0; e_wbq = 2'd0; e_wbd = 16'h0; e_err = 1'b0;
            end else if (!m_busy) begin
                e_err = 1'b0;
                if (ReadMem || WriteMem) begin
                    e_stall = 1'b1; m_busy = 1'b1; m_age = 0;
                    m_rd = ReadMem; m_q = quarter; m_w = write;
                    e_req = 1'b1; e_we = WriteMem && !ReadMem;
                    e_addr = DataAddress; e_wdata = DataIn;
                    e_wbv = 1'b0; e_wbw = 1'b0;
                end else begin
                    e_stall = 1'b0;
                    e_wbv = 1'b1; e_wbw = write; e_wbq = quarter; e_wbd = DataAddress;
                end
            end else begin
                m_age++;
                if (ram_ack) begin
                    e_stall = 1'b0; m_busy = 1'b0; e_req = 1'b0; e_err = 1'b0;
                    e_wbv = 1'b1; e_wbw = m_rd ? m_w : 1'b0; e_wbq = m_q;
                    e_wbd = m_rd ? ram_rdata : 16'h0000;
                end else if (m_age == TO) begin
                    e_stall = 1'b0; m_busy = 1'b0; e_req = 1'b0; e_err = 1'b1;
                    e_wbv = 1'b1; e_wbw = 1'b0; e_wbq = m_q;
                end else begin
                    e_stall = 1'b1; e_wbv = 1'b0; e_wbw = 1'b0; e_err = 1'b0;
                end
            end

            #1;
            chk("rnd_stall", {31'd0, stall}, {31'd0, e_stall});
            tick();
            chk("rnd_ctl", {27'd0, ram_req, wb_valid, wb_write, mem_err, 1'b0},
                           {27'd0, e_req, e_wbv, e_wbw, e_err, 1'b0});
            if (e_req) chk("rnd_ram", {ram_we, ram_addr, ram_wdata[14:0]}, {e_we, e_addr, e_wdata[14:0]});
            if (e_req) chk("rnd_ram_wd15", {31'd0, ram_wdata[15]}, {31'd0, e_wdata[15]});
            if (e_wbv) chk("rnd_wb_quarter", {30'd0, wb_quarter}, {30'd0, e_wbq});
            if (e_wbv && !e_err) chk("rnd_wb_data", {16'd0, wb_data}, {16'd0, e_wbd});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory stage of the 16-bit pipelined CPU. It sits directly downstream of the EX/MEM pipeline register and consumes its address, store data, read/write controls, 2-bit destination register (`quarter`) and register-write flag. It runs a request/acknowledge access to the data RAM and stalls upstream stages until the RAM answers or a timeout expires. It then presents registered write-back data to the MEM/WB stage.

## Interface
Parameters:
- `ADDR_W`, 16: data address width.
- `DATA_W`, 16: data word width.
- `TIMEOUT`, 15: maximum cycles spent in ACCESS before abort (1..255).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `DataAddress` in ADDR_W: memory address for loads/stores; ALU result for non-memory ops.
- `DataIn` in DATA_W: store data.
- `ReadMem` in 1: load request.
- `WriteMem` in 1: store request.
- `quarter` in 2: destination register index.
- `write` in 1: instruction writes the register file.
- `stall` out 1: hold all upstream stages (combinational).
- `ram_req` out 1: RAM request, registered.
- `ram_we` out 1: 1 = write, registered.
- `ram_addr` out ADDR_W: registered RAM address.
- `ram_wdata` out DATA_W: registered store data.
- `ram_ack` in 1: RAM completion, single-cycle pulse.
- `ram_rdata` in DATA_W: load data, valid when `ram_ack`=1.
- `wb_valid` out 1: write-back slot holds a retired instruction.
- `wb_write` out 1: register-file write enable.
- `wb_quarter` out 2: destination register.
- `wb_data` out DATA_W: write-back value.
- `mem_err` out 1: one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, neither `ReadMem` nor `WriteMem` set:
  - the instruction retires at the next edge: `wb_valid`=1, `wb_write`=`write`, `wb_quarter`=`quarter`, `wb_data`=`DataAddress`;
  - `stall`=0.
- IDLE, `ReadMem` or `WriteMem` set:
  - `stall`=1;
  - at the edge: capture address, data, `ram_we`=`WriteMem & ~ReadMem` (read wins if both are set), `quarter` and `write`;
  - set `ram_req`=1, clear the timeout counter, go to ACCESS;
  - the next write-back slot is a bubble (`wb_valid`=0, `wb_write`=0).
- ACCESS:
  - inputs are ignored; `ram_req`, `ram_we`, `ram_addr` and `ram_wdata` hold stable;
  - `stall`=1 unless `ram_ack`=1 or counter==TIMEOUT-1.
- ACCESS with `ram_ack`:
  - `stall`=0; at the edge `ram_req`=0, go to IDLE;
  - load: `wb_valid`=1, `wb_write`=captured `write`, `wb_data`=`ram_rdata`;
  - store: `wb_valid`=1, `wb_write`=0, `wb_data`=0.
- ACCESS with counter==TIMEOUT-1 and no ack:
  - `stall`=0; at the edge `ram_req`=0, go to IDLE;
  - `mem_err`=1 for one cycle; `wb_valid`=1, `wb_write`=0 (the load is dropped).
- Ack and timeout in the same cycle: the ack wins, `mem_err`=0.
- `ram_ack` in IDLE is ignored.
- Timeout counter: 8 bits, increments each ACCESS cycle, saturates.

## Timing
- Reset (sync, `rst_n`=0 at an edge):
  - state goes to IDLE;
  - `ram_req`, `ram_we`, `ram_addr`, `ram_wdata`, `wb_valid`, `wb_write`, `wb_quarter`, `wb_data`, `mem_err` all become 0;
  - the counter becomes 0.
- `stall` is 0 while `rst_n`=0.
- Reset during ACCESS aborts the access with no `mem_err`; `ram_req` is low from the next cycle.
- Non-memory op latency: 1 cycle to write-back.
- Memory op latency: 1 + N cycles, where N is the cycle count from the first `ram_req` to `ram_ack` inclusive; `stall` is high for exactly N cycles.
- Back-to-back memory ops:
  - the upstream advances on the ack edge;
  - the following op is seen in IDLE the next cycle;
  - `ram_req` is low for at least one cycle between requests.

## Structure
- Shared package `mem_stage_pkg` holds:
  - the state enum (IDLE, ACCESS);
  - the counter width constant (8);
  - the default TIMEOUT.
- There is no sub-module; a single module contains the FSM, the capture registers, the counter and the write-back registers.

## Test plan
- Reset with `rst_n`=0 held for 2 cycles and `ReadMem`=1 -> all outputs 0, `stall`=0, `ram_req` never rises.
- ALU op with `DataAddress`=0x1234, `write`=1, `quarter`=2 -> the next cycle shows `wb_valid`=1, `wb_write`=1, `wb_quarter`=2, `wb_data`=0x1234, and `stall` is never high.
- Load from 0x0040 with `ram_ack` arriving 3 cycles after `ram_req` and `ram_rdata`=0xBEEF -> `stall` high for 4 cycles, then `wb_data`=0xBEEF, `wb_write`=1, `wb_quarter` equal to the captured value.
- Store to 0x0010 of 0xA5A5 with an ack after 1 cycle -> `ram_we`=1, `ram_addr`=0x0010, `ram_wdata`=0xA5A5 stable while `ram_req` is high, then `wb_valid`=1, `wb_write`=0.
- Load with no ack and TIMEOUT=4 -> `ram_req` high for 4 cycles, then a `mem_err` pulse, `wb_write`=0 and the FSM back in IDLE.
- Load followed immediately by a store, with reset asserted mid-way through the second access -> the first load retires correctly, the second access aborts, `ram_req` is 0 and `mem_err` is 0.
